aline_pingpong_buffer: RTL
==========================

// Module: aline_pingpong_buffer
// PURPOSE
// - Downstream of the A-line acquisition stage. Captures each 14-bit A-line sample at its sample position into one bank of a two-bank RAM.
// - On completion of a sweep, commits the bank and streams it out with valid/ready handshake (host/DMA side).
// - The other bank takes the next sweep. A sweep arriving while both banks are full is dropped and counted.
// PARAMETERS
// - NSAMPLES  1170  samples per A-line (valid sample_pos 1..NSAMPLES)
// - DATA_W    14    sample width
// - ADDR_W    11    sample address width
// PORTS
// - clk_system    in   1       single clock; all inputs synchronous to it
// - global_reset  in   1       synchronous, active-high reset
// - sample_pos    in   ADDR_W  upstream sample position; 0 = idle
// - A_line_in     in   DATA_W  sample belonging to address sample_pos-1
// - acq_busy      in   1       high while a sweep is acquiring
// - out_ready     in   1       consumer ready
// - out_valid     out  1       out_data valid
// - out_data      out  16      {2'b00, sample}
// - out_sop       out  1       first sample of line (qualified by out_valid)
// - out_eop       out  1       last sample of line (qualified by out_valid)
// - line_cnt      out  16      lines fully streamed, wraps at 0xFFFF->0
// - drop_cnt      out  16      lines dropped (overflow or short), saturates at 0xFFFF
// - bank_full     out  2       per-bank committed flag
// BEHAVIOUR
// Reset (synchronous, global_reset=1 at posedge):
// - out_valid/out_sop/out_eop = 0, out_data = 0, line_cnt = 0, drop_cnt = 0, bank_full = 0.
// - Write bank = 0. Reader FSM -> R_IDLE. Writer FSM -> W_SKIP.
// - A partial line in progress at reset is discarded; RAM contents are not cleared.
// Writer FSM: W_SKIP, W_ARMED, W_WRITE, W_DROP.
// - W_SKIP: wait for acq_busy=0, then -> W_ARMED. No mid-sweep start, including after reset.
// - W_ARMED, acq_busy rises:
//   - wr bank empty -> W_WRITE, clear max_addr.
//   - wr bank full -> W_DROP.
// - W_WRITE, each cycle with sample_pos in 1..NSAMPLES:
//   - Write A_line_in to {wr_bank, sample_pos-1}. Repeated positions overwrite (idempotent).
//   - Track max_addr.
//   - sample_pos > NSAMPLES is ignored.
// - W_WRITE, acq_busy falls:
//   - max_addr == NSAMPLES-1: set bank_full[wr_bank], toggle wr_bank.
//   - Otherwise: short line, bank not committed, drop_cnt+1.
//   - Either way -> W_ARMED.
// - W_DROP: on acq_busy fall, drop_cnt+1, -> W_ARMED.
// Reader FSM: R_IDLE, R_PRIME, R_STREAM.
// - Bank selection and order:
//   - rd_bank is a separate pointer, reset to 0; it follows commit order.
//   - Lines leave strictly in acquisition order, never reordered.
// - R_IDLE: bank_full[rd_bank]=1 -> R_PRIME. Issue read addr 0 (RAM latency 1 clk).
// - R_PRIME: load output register -> R_STREAM.
//   - out_valid rises 2 clks after bank_full is seen.
//   - out_sop=1 with addr 0.
// - R_STREAM:
//   - Transfer occurs when out_valid && out_ready.
//   - Held data stable while out_ready=0. No bubbles while out_ready=1.
//   - Throughput 1 sample/clk via one-entry prefetch/skid register.
//   - out_eop=1 with addr NSAMPLES-1.
//   - On eop transfer: clear bank_full[rd_bank], toggle rd_bank, line_cnt+1, -> R_IDLE.
// - Simultaneous commit (writer) and release (reader) of different banks in the same cycle: both take effect.
// - Write and read never target the same bank: the writer only writes a bank with bank_full=0.
// STRUCTURE
// - Shared include file holds: NSAMPLES, DATA_W, ADDR_W, writer/reader state encodings.
// - One sub-module: aline_dp_ram.
//   - Simple dual-port: 1 write port, 1 read port.
//   - Depth 2*NSAMPLES, address {bank, addr}.
//   - Registered read, latency 1.
// - Top holds both FSMs, counters, and skid register.
// TESTING
// - Reset, then one clean sweep: sample_pos 1..1170 with data = pos.
//   - Expect 1170 beats, data 0x0001..0x0492, sop on the first beat, eop on the last.
//   - line_cnt=1.
// - Backpressure: toggle out_ready randomly 50%.
//   - Identical data sequence, no loss or duplication.
//   - out_data stable whenever valid && !ready.
// - Overflow: out_ready=0, three sweeps.
//   - bank_full=2'b11 after two sweeps; third sweep dropped, drop_cnt=1.
//   - Release out_ready: lines 1 then 2 emerge in order, with their own data.
// - Short sweep: acq_busy falls at sample_pos=600.
//   - drop_cnt+1, no output.
//   - Next full sweep uses the same bank and streams correctly.
// - Reset mid-sweep with acq_busy=1 at release:
//   - Writer ignores that sweep until acq_busy=0.
//   - All outputs 0; the next sweep streams normally.
// - Commit/release collision: time the eop transfer of bank 0 in the same clk as the commit of bank 1.
//   - bank_full goes 01 -> 10 in one clk; streaming of bank 1 starts 2 clks later.

Source files
------------

// File: rtl/aline_pingpong_buffer_pkg.sv
// Shared constants and state encodings for the A-line ping-pong buffer.
//   NSAMPLES   samples per A-line (sample_pos 1..NSAMPLES)
//   DATA_W     A-line sample width
//   ADDR_W     sample address width
//   OUT_W      streamed word width ({zero pad, sample})
package aline_pingpong_buffer_pkg;

    localparam int NSAMPLES  = 1170;
    localparam int DATA_W    = 14;
    localparam int ADDR_W    = 11;
    localparam int OUT_W     = 16;
    localparam int RAM_DEPTH = 2 * NSAMPLES;
    localparam int RAM_IDX_W = $clog2(RAM_DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NSAMPLES - 1);
    localparam logic [ADDR_W-1:0] NSAMPLES_A = ADDR_W'(NSAMPLES);

    typedef enum logic [1:0] {
        W_SKIP,
        W_ARMED,
        W_WRITE,
        W_DROP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PRIME,
        R_STREAM
    } rd_state_t;

    function automatic logic pos_in_range(input logic [ADDR_W-1:0] pos);
        return (pos != '0) && (pos <= NSAMPLES_A);
    endfunction

endpackage

// File: rtl/aline_pingpong_buffer_ram.sv
// Two-bank sample store: simple dual-port RAM, one write port, one read port.
// The two banks are packed back to back (depth 2*NSAMPLES); {bank, addr} is
// folded to a linear index so no address space is wasted.
// Ports:
//   clk_system  clock
//   we/wbank/waddr/wdata   write port
//   re/rbank/raddr         read request; rdata registered, latency 1,
//                          holds its value while re=0
//   rdata       read data
module aline_dp_ram
    import aline_pingpong_buffer_pkg::*;
(
    input  logic              clk_system,
    input  logic              we,
    input  logic              wbank,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rbank,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0]    mem [RAM_DEPTH];
    logic [RAM_IDX_W-1:0] widx;
    logic [RAM_IDX_W-1:0] ridx;

    function automatic logic [RAM_IDX_W-1:0] to_idx(input logic bank,
                                                    input logic [ADDR_W-1:0] addr);
        return bank ? (RAM_IDX_W'(addr) + RAM_IDX_W'(NSAMPLES)) : RAM_IDX_W'(addr);
    endfunction

    assign widx = to_idx(wbank, waddr);
    assign ridx = to_idx(rbank, raddr);

    always_ff @(posedge clk_system) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    // The hold-when-idle behaviour makes this register the reader's prefetch stage.
    always_ff @(posedge clk_system) begin
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/aline_pingpong_buffer.sv
// A-line ping-pong buffer: captures each sweep into one of two RAM banks and
// streams committed banks out in acquisition order over valid/ready.
// Ports:
//   clk_system    clock
//   global_reset  synchronous active-high reset
//   sample_pos    upstream sample position, 0 = idle, 1..NSAMPLES valid
//   A_line_in     sample for address sample_pos-1
//   acq_busy      high while a sweep is acquiring
//   out_ready     consumer ready
//   out_valid     out_data valid
//   out_data      {2'b00, sample}
//   out_sop       first sample of line
//   out_eop       last sample of line
//   line_cnt      lines fully streamed (wrapping)
//   drop_cnt      lines dropped, overflow or short (saturating)
//   bank_full     per-bank committed flag
//
// Writer states:
//   W_SKIP   | waiting for acq_busy low (no mid-sweep start)
//   W_ARMED  | idle between sweeps, waiting for acq_busy rise
//   W_WRITE  | writing a sweep into the write bank
//   W_DROP   | both banks full, discarding this sweep
// Reader states:
//   R_IDLE   | waiting for bank_full[rd_bank]; issues read of addr 0
//   R_PRIME  | first RAM word arriving, loaded into the output register
//   R_STREAM | streaming until the eop beat transfers
module aline_pingpong_buffer
    import aline_pingpong_buffer_pkg::*;
(
    input  logic              clk_system,
    input  logic              global_reset,
    input  logic [ADDR_W-1:0] sample_pos,
    input  logic [DATA_W-1:0] A_line_in,
    input  logic              acq_busy,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [15:0]       line_cnt,
    output logic [15:0]       drop_cnt,
    output logic [1:0]        bank_full
);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] max_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              pos_ok;

    logic              ram_we;
    logic              clr_max;
    logic              commit;
    logic              w_drop;

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] p_addr;
    logic              p_vld;
    logic              advance;
    logic              release_bank;
    logic              start_read;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic [1:0]        bf_set;
    logic [1:0]        bf_clr;

    assign pos_ok  = pos_in_range(sample_pos);
    assign wr_addr = sample_pos - ADDR_W'(1);

    // ---------------- writer FSM ----------------
    // W_ARMED is only entered with acq_busy low, so acq_busy high there is a
    // rising edge. The first cycle of a sweep may already carry a sample.
    always_comb begin
        w_next  = w_state;
        ram_we  = 1'b0;
        clr_max = 1'b0;
        commit  = 1'b0;
        w_drop  = 1'b0;
        case (w_state)
            W_SKIP: begin
                if (!acq_busy) begin
                    w_next = W_ARMED;
                end
            end
            W_ARMED: begin
                if (acq_busy) begin
                    if (!bank_full[wr_bank]) begin
                        w_next  = W_WRITE;
                        clr_max = 1'b1;
                        ram_we  = pos_ok;
                    end else begin
                        w_next = W_DROP;
                    end
                end
            end
            W_WRITE: begin
                if (acq_busy) begin
                    ram_we = pos_ok;
                end else begin
                    if (max_addr == LAST_ADDR) begin
                        commit = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                    w_next = W_ARMED;
                end
            end
            W_DROP: begin
                if (!acq_busy) begin
                    w_drop = 1'b1;
                    w_next = W_ARMED;
                end
            end
            default: w_next = W_SKIP;
        endcase
    end

    // ---------------- reader FSM ----------------
    // Output register + RAM output register form a two-stage pipeline that
    // advances together; a stalled consumer freezes both, giving one beat per
    // clock without bubbles and stable data under backpressure.
    assign advance      = !out_valid || out_ready;
    assign release_bank = out_valid && out_ready && out_eop;

    always_comb begin
        r_next     = r_state;
        start_read = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (bank_full[rd_bank]) begin
                    r_next     = R_PRIME;
                    start_read = 1'b1;
                end
            end
            R_PRIME: r_next = R_STREAM;
            R_STREAM: begin
                if (release_bank) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ram_re    = advance && (start_read ||
                       ((r_state != R_IDLE) && (rd_ptr != NSAMPLES_A)));
    assign ram_raddr = start_read ? '0 : rd_ptr;

    assign bf_set = commit       ? (2'b01 << wr_bank) : 2'b00;
    assign bf_clr = release_bank ? (2'b01 << rd_bank) : 2'b00;

    aline_dp_ram u_ram (
        .clk_system (clk_system),
        .we         (ram_we),
        .wbank      (wr_bank),
        .waddr      (wr_addr),
        .wdata      (A_line_in),
        .re         (ram_re),
        .rbank      (rd_bank),
        .raddr      (ram_raddr),
        .rdata      (ram_rdata)
    );

    always_ff @(posedge clk_system) begin
        if (global_reset) begin
            w_state <= W_SKIP;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_ff @(posedge clk_system) begin
        if (global_reset) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= 2'b00;
            max_addr  <= '0;
            line_cnt  <= '0;
            drop_cnt  <= '0;
            rd_ptr    <= '0;
            p_addr    <= '0;
            p_vld     <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
        end else begin
            // Commit and release always hit different banks, so both apply.
            bank_full <= (bank_full & ~bf_clr) | bf_set;
            if (commit) begin
                wr_bank <= ~wr_bank;
            end
            if (release_bank) begin
                rd_bank  <= ~rd_bank;
                line_cnt <= line_cnt + 16'd1;
            end
            if (w_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            if (clr_max) begin
                max_addr <= ram_we ? wr_addr : '0;
            end else if (ram_we && (wr_addr > max_addr)) begin
                max_addr <= wr_addr;
            end

            if (advance) begin
                out_valid <= p_vld;
                out_sop   <= p_vld && (p_addr == '0);
                out_eop   <= p_vld && (p_addr == LAST_ADDR);
                if (p_vld) begin
                    out_data <= {{(OUT_W-DATA_W){1'b0}}, ram_rdata};
                end
                p_vld <= ram_re;
                if (ram_re) begin
                    p_addr <= ram_raddr;
                    rd_ptr <= ram_raddr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
